dir_cmd_arbiter: RTL

//  Merges direction requests from the push-buttons, the PS/2 keyboard and the online link into one ordered turn stream.

---
 rtl/dir_cmd_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dir_cmd_arbiter.sv
// Merges button, keyboard and network direction requests into one ordered turn stream.
// Round-robin arbitration, reversal/duplicate filtering, and a small turn queue drained by move_tick.
module dir_cmd_arbiter #(
    parameter int         DEPTH     = 4,
    parameter logic [1:0] DIR_RESET = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic [3:0] src_btn,
    input  logic [3:0] src_kbd,
    input  logic [3:0] src_net,
    input  logic       move_tick,
    output logic [1:0] dir_out,
    output logic [2:0] q_count,
    output logic [2:0] grant,
    output logic       drop
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Lowest set bit wins: left > right > up > down.
    function automatic logic [1:0] first_dir(input logic [3:0] r);
        logic [1:0] d;
        if (r[0])      d = 2'd0;
        else if (r[1]) d = 2'd1;
        else if (r[2]) d = 2'd2;
        else           d = 2'd3;
        return d;
    endfunction

    function automatic logic [1:0] rot_idx(input logic [1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 3) s = s - 3;
        return 2'(s);
    endfunction

    logic        sync_clr;
    logic [11:0] src_all;
    logic [2:0]  pend_valid;
    logic [5:0]  pend_dir;

    logic        pick_valid;
    logic [1:0]  pick_src;
    logic [1:0]  pick_dir;
    logic [2:0]  grant_next;

    logic [1:0]  rr_reg;
    logic [2:0]  grant_reg;
    logic        drop_reg;
    logic [1:0]  dir_reg;

    logic [1:0]    queue_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count_reg;

    logic [1:0] ref_dir;
    logic       is_dup;
    logic       is_rev;
    logic       is_full;
    logic       do_push;
    logic       do_pop;
    logic       drop_next;

    assign sync_clr = rst || clr;
    assign src_all  = {src_net, src_kbd, src_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            logic [3:0] prev_reg;
            logic [3:0] rise_reg;
            logic       pend_valid_reg;
            logic [1:0] pend_dir_reg;

            // History starts all-ones so levels held through reset never look like a press.
            always_ff @(posedge clk) begin
                if (sync_clr) begin
                    prev_reg <= 4'hF;
                    rise_reg <= 4'h0;
                end else begin
                    prev_reg <= src_all[gi*4 +: 4];
                    rise_reg <= src_all[gi*4 +: 4] & ~prev_reg;
                end
            end

            // A fresh rise beats the clear from a simultaneous grant: latest request wins.
            always_ff @(posedge clk) begin
                if (sync_clr) begin
                    pend_valid_reg <= 1'b0;
                    pend_dir_reg   <= 2'd0;
                end else if (|rise_reg) begin
                    pend_valid_reg <= 1'b1;
                    pend_dir_reg   <= first_dir(rise_reg);
                end else if (grant_next[gi]) begin
                    pend_valid_reg <= 1'b0;
                end
            end

            assign pend_valid[gi]       = pend_valid_reg;
            assign pend_dir[gi*2 +: 2]  = pend_dir_reg;
        end
    endgenerate

    // Scan from the rr pointer; iterating backwards lets the nearest valid source win.
    always_comb begin
        pick_valid = 1'b0;
        pick_src   = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (pend_valid[rot_idx(rr_reg, k)]) begin
                pick_valid = 1'b1;
                pick_src   = rot_idx(rr_reg, k);
            end
        end
    end

    assign pick_dir   = pend_dir[{pick_src, 1'b0} +: 2];
    assign grant_next = pick_valid ? (3'b001 << pick_src) : 3'b000;

    assign tail_ptr  = wr_ptr_reg - PTR_ONE;
    assign ref_dir   = (count_reg != '0) ? queue_mem[tail_ptr] : dir_reg;
    assign is_dup    = (pick_dir == ref_dir);
    assign is_rev    = (pick_dir == (ref_dir ^ 2'b01));
    assign is_full   = (count_reg == CNT_FULL);
    assign do_push   = pick_valid && !is_dup && !is_rev && !is_full;
    assign drop_next = pick_valid && !do_push;
    assign do_pop    = move_tick && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            queue_mem[wr_ptr_reg] <= pick_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            rr_reg     <= 2'd0;
            grant_reg  <= 3'b000;
            drop_reg   <= 1'b0;
            dir_reg    <= DIR_RESET;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            grant_reg <= grant_next;
            drop_reg  <= drop_next;
            if (pick_valid) begin
                rr_reg <= (pick_src == 2'd2) ? 2'd0 : pick_src + 2'd1;
            end
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                dir_reg    <= queue_mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dir_out = dir_reg;
    assign q_count = 3'(count_reg);
    assign grant   = grant_reg;
    assign drop    = drop_reg;

endmodule
